gcd_datapath: RTL

Datapath partner of the GCD control path, the subtract/swap FSM with state bits D0/D1. Accepts one operand pair over a valid/ready input handshake and holds the working registers XR/YR. It executes the load, subtract and swap commands issued by the control path and returns the status flags I0/I1 to it. It detects termination and presents the GCD, the operation count and an error flag over a valid/ready output handshake.

---
 rtl/gcd_datapath.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/gcd_datapath.sv
// Datapath half of a subtract/swap GCD engine: staging register, working
// registers XR/YR, look-ahead status flags, operation counter and result port.
module gcd_datapath #(
    parameter int W  = 8,
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_x,
    input  logic [W-1:0]  in_y,
    input  logic          Subtract,
    input  logic          Swap,
    input  logic          LoadXR,
    input  logic          LoadYR,
    input  logic          SelectXY,
    output logic          I0,
    output logic          I1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_gcd,
    output logic [CW-1:0] out_cycles,
    output logic          out_err
);

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_ARMED,
        PH_RUN,
        PH_DONE,
        PH_SPENT
    } phase_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    phase_t        phase_q, phase_d;
    logic [W-1:0]  sx_q, sx_d, sy_q, sy_d;
    logic [W-1:0]  xr_q, xr_d, yr_q, yr_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [W-1:0]  gcd_q, gcd_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          err_q, err_d;
    logic          vld_q, vld_d;
    logic          op;

    assign cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
            xr_q    <= '0;
            yr_q    <= '0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            cyc_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end

    // xr_d/yr_d are the values the working registers take at the coming
    // edge; the flags are derived from them so the control path never
    // issues a subtract that would underflow.
    always_comb begin
        phase_d = phase_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        cnt_d   = cnt_q;
        gcd_d   = gcd_q;
        cyc_d   = cyc_q;
        err_d   = err_q;
        vld_d   = vld_q;
        op      = 1'b0;
        case (phase_q)
            PH_IDLE: begin
                if (in_valid) begin
                    sx_d    = in_x;
                    sy_d    = in_y;
                    phase_d = PH_ARMED;
                end
            end
            PH_ARMED: begin
                if (SelectXY) begin
                    xr_d    = sx_q;
                    yr_d    = sy_q;
                    cnt_d   = '0;
                    phase_d = PH_RUN;
                end
            end
            PH_RUN: begin
                if (Subtract) begin
                    xr_d = xr_q - yr_q;
                    op   = 1'b1;
                end else if (Swap) begin
                    xr_d = yr_q;
                    yr_d = xr_q;
                    op   = 1'b1;
                end
                if (op) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        err_d   = 1'b1;
                        gcd_d   = '0;
                        cyc_d   = CNT_MAX;
                        vld_d   = 1'b1;
                        phase_d = PH_DONE;
                    end
                end else if (!LoadXR && !LoadYR) begin
                    gcd_d   = yr_q;
                    cyc_d   = cnt_q;
                    err_d   = 1'b0;
                    vld_d   = 1'b1;
                    phase_d = PH_DONE;
                end
            end
            PH_DONE: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    phase_d = PH_SPENT;
                end
            end
            PH_SPENT: begin
            end
            default: begin
                phase_d = PH_IDLE;
            end
        endcase
    end

    // Before operands are loaded the flags pin the control path in its load state.
    always_comb begin
        I0 = (xr_d != '0);
        I1 = (xr_d >= yr_d);
        if (phase_q == PH_IDLE || (phase_q == PH_ARMED && !SelectXY)) begin
            I0 = 1'b1;
            I1 = 1'b0;
        end
    end

    assign in_ready   = (phase_q == PH_IDLE);
    assign out_valid  = vld_q;
    assign out_gcd    = gcd_q;
    assign out_cycles = cyc_q;
    assign out_err    = err_q;

endmodule
